alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 16, 32, 64).
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width (derived, not overridden).
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 valid_i  input  1  operation request.
REQ-006 ready_o  output  1  unit can accept a request this cycle.
REQ-007 op_i  input  4  opcode: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 10 LUI, 11 MUL, 12 MULHU, 13 DIVU, 14 REMU, 15 reserved.
REQ-008 operand_a_i  input  XLEN  first operand.
REQ-009 operand_b_i  input  XLEN  second operand / shift amount / LUI immediate.
REQ-010 valid_o  output  1  single-cycle pulse: result_o valid.
REQ-011 result_o  output  XLEN  registered result.
REQ-012 nonzero_o  output  1  OR-reduction of result_o, valid with valid_o.

Function
REQ-013 Request accepted when valid_i && ready_o; operands and opcode captured that edge; valid_i ignored when ready_o low.
REQ-014 FSM states IDLE, MUL, DIV, DONE; ready_o high only in IDLE.
REQ-015 Ops 0-10 and 15: result registered at accept edge, valid_o high the following cycle (latency 1), FSM stays IDLE, back-to-back accepts every cycle.
REQ-016 ADD/SUB modulo 2^XLEN; SLT signed compare, SLTU unsigned compare, result 1 or 0 zero-extended.
REQ-017 SLL/SRL/SRA shift by operand_b_i[SHW-1:0]; SRA replicates operand_a_i[XLEN-1].
REQ-018 LUI returns operand_b_i unchanged; opcode 15 returns 0.
REQ-019 MUL/MULHU: IDLE->MUL, shift-add one bit per cycle for XLEN cycles, ->DONE; MUL returns low XLEN bits, MULHU high XLEN bits of unsigned 2*XLEN product.
REQ-020 DIVU/REMU: IDLE->DIV, restoring division one quotient bit per cycle for XLEN cycles, ->DONE; DIVU returns quotient, REMU remainder.
REQ-021 Iteration counter width SHW+1, loaded at accept, terminates exactly after XLEN iterations.
REQ-022 DONE: result_o updated, valid_o high one cycle, next state IDLE; iterative latency accept-to-valid_o = XLEN+1 cycles.
REQ-023 Divide by zero: no iteration, IDLE->DONE directly; DIVU returns all ones, REMU returns operand_a_i; latency 1.
REQ-024 result_o holds last value until next completion; no output backpressure.

Reset
REQ-025 rst_i high: FSM->IDLE, counter 0, result_o 0, valid_o 0, ready_o 1 next cycle.
REQ-026 rst_i during MUL/DIV aborts the operation; no valid_o is produced for it.
REQ-027 rst_i overrides a simultaneous valid_i; request is not accepted.

Configuration
REQ-028 Macro ALU_MC_DIV_EN defined: DIVU/REMU implemented per REQ-020/023.
REQ-029 ALU_MC_DIV_EN undefined: DIV state and divider datapath absent; opcodes 13/14 behave as opcode 15 (result 0, latency 1).

Verification
REQ-030 XLEN=32, ADD 0xFFFFFFFF+1 -> next cycle valid_o=1, result_o=0, nonzero_o=0; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-031 SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0; back-to-back accepts give valid_o on consecutive cycles.
REQ-032 MULHU 0xFFFFFFFF*0xFFFFFFFF -> valid_o 33 cycles after accept, result 0xFFFFFFFE; ready_o low for 32 cycles between.
REQ-033 DIVU 100/7 -> 14, REMU -> 2 after 33 cycles; DIVU x/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, each 1 cycle.
REQ-034 rst_i asserted 10 cycles into MUL -> no valid_o, ready_o=1 cycle after; new ADD completes normally.
REQ-035 Build without ALU_MC_DIV_EN: DIVU 100/7 -> result 0, latency 1.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add multiply
// and optional restoring divide (enabled by defining ALU_MC_DIV_EN).
module alu_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            nonzero_o
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLT   = 4'd2;
    localparam logic [3:0] OP_SLTU  = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_LUI   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REMU  = 4'd14;
`endif
    localparam logic [SHW:0] ITER   = (SHW+1)'(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef ALU_MC_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [SHW:0]        cnt_q, cnt_d;
    logic [3:0]          op_q, op_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                valid_q, valid_d;
    logic                nonzero_q, nonzero_d;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
`ifdef ALU_MC_DIV_EN
    logic                div_ge;
    logic [XLEN-1:0]     div_diff;
    logic [XLEN-1:0]     div_rem;
    logic [2*XLEN-1:0]   div_next;
`endif

    function automatic logic [XLEN-1:0] alu_simple(
        input logic [3:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_SLL:  r = a << b[SHW-1:0];
            OP_SRL:  r = a >> b[SHW-1:0];
            OP_SRA:  r = $unsigned($signed(a) >>> b[SHW-1:0]);
            OP_LUI:  r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // One shift-add multiply step: prod holds {partial high, remaining multiplier}
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? opnd_q : {XLEN{1'b0}})};
        mul_next = {mul_sum, prod_q[XLEN-1:1]};
    end

`ifdef ALU_MC_DIV_EN
    // One restoring divide step: prod holds {remainder, dividend/quotient}
    always_comb begin
        div_ge   = prod_q[2*XLEN-1:XLEN-1] >= {1'b0, opnd_q};
        div_diff = prod_q[2*XLEN-2:XLEN-1] - opnd_q;
        div_rem  = div_ge ? div_diff : prod_q[2*XLEN-2:XLEN-1];
        div_next = {div_rem, prod_q[XLEN-2:0], div_ge};
    end
`endif

    // Next-state, datapath and result selection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        prod_d    = prod_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    op_d = op_i;
                    case (op_i)
                        OP_MUL, OP_MULHU: begin
                            state_d = S_MUL;
                            cnt_d   = ITER;
                            opnd_d  = operand_a_i;
                            prod_d  = {{XLEN{1'b0}}, operand_b_i};
                        end
`ifdef ALU_MC_DIV_EN
                        OP_DIVU, OP_REMU: begin
                            if (operand_b_i == {XLEN{1'b0}}) begin
                                state_d  = S_DONE;
                                valid_d  = 1'b1;
                                result_d = (op_i == OP_DIVU) ? {XLEN{1'b1}} : operand_a_i;
                            end else begin
                                state_d = S_DIV;
                                cnt_d   = ITER;
                                opnd_d  = operand_b_i;
                                prod_d  = {{XLEN{1'b0}}, operand_a_i};
                            end
                        end
`endif
                        default: begin
                            valid_d  = 1'b1;
                            result_d = alu_simple(op_i, operand_a_i, operand_b_i);
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q - (SHW+1)'(1);
                if (cnt_q == (SHW+1)'(1)) begin
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    result_d = (op_q == OP_MULHU) ? mul_next[2*XLEN-1:XLEN] : mul_next[XLEN-1:0];
                end else begin
                    state_d = S_MUL;
                end
            end
`ifdef ALU_MC_DIV_EN
            S_DIV: begin
                prod_d = div_next;
                cnt_d  = cnt_q - (SHW+1)'(1);
                if (cnt_q == (SHW+1)'(1)) begin
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    result_d = (op_q == OP_REMU) ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
                end else begin
                    state_d = S_DIV;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        nonzero_d = |result_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= 4'd0;
            opnd_q    <= '0;
            prod_q    <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            nonzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            prod_q    <= prod_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            nonzero_q <= nonzero_d;
        end
    end

    assign ready_o   = (state_q == S_IDLE);
    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign nonzero_o = nonzero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc (XLEN=32) against an arithmetic
// reference model; expectations for opcodes 13/14 follow ALU_MC_DIV_EN.
module tb_alu_mc;

    logic        clk;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        valid_o;
    logic [31:0] result_o;
    logic        nonzero_o;

    int total = 0;
    int bad   = 0;

    alu_mc #(.XLEN(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .op_i        (op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .nonzero_o   (nonzero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        int unsigned sh;
        logic [31:0] ones;
        sh   = b % 32;
        ones = 32'hFFFF_FFFF;
        p    = longint'(a) * longint'(b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd4:  return a ^ b;
            4'd5:  return a | b;
            4'd6:  return a & b;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
            4'd10: return b;
            4'd11: return p[31:0];
            4'd12: return p[63:32];
`ifdef ALU_MC_DIV_EN
            4'd13: return (b == 32'd0) ? ones : a / b;
            4'd14: return (b == 32'd0) ? a : a % b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_latency(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd11 || op == 4'd12) return 33;
`ifdef ALU_MC_DIV_EN
        if ((op == 4'd13 || op == 4'd14) && b != 32'd0) return 33;
`endif
        return 1;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        int low_cnt;
        int waited;
        int exp_lat;
        logic [31:0] exp_res;
        exp_res = model_result(op, a, b);
        exp_lat = model_latency(op, b);
        waited  = 0;
        while (!ready_o && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        chk({tag, "_ready"}, 64'(ready_o), 64'd1);
        @(negedge clk);
        valid_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1; low_cnt = 0;
        while (!valid_o && lat < 100) begin
            if (!ready_o) low_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, 64'(result_o), 64'(exp_res));
        chk({tag, "_nz"}, 64'(nonzero_o), 64'(exp_res != 32'd0));
        chk({tag, "_busy"}, 64'(low_cnt), 64'(exp_lat - 1));
    endtask

    initial begin
        logic [31:0] a, b;
        logic [3:0]  op;
        logic [31:0] exp_q[$];
        int seen;

        rst_i = 1'b1; valid_i = 1'b0; op_i = 4'd0; operand_a_i = 32'd0; operand_b_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_result", 64'(result_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        rst_i = 1'b0;

        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
        run_op("sra", 4'd9, 32'h8000_0000, 32'd4);
        run_op("slt", 4'd2, 32'hFFFF_FFFF, 32'd1);
        run_op("sltu", 4'd3, 32'hFFFF_FFFF, 32'd1);
        run_op("lui", 4'd10, 32'd0, 32'h1234_5000);
        run_op("rsvd", 4'd15, 32'd7, 32'd9);
        run_op("mulhu", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mul", 4'd11, 32'h0001_0003, 32'h0002_0005);
        run_op("divu", 4'd13, 32'd100, 32'd7);
        run_op("remu", 4'd14, 32'd100, 32'd7);
        run_op("divu_z", 4'd13, 32'd12345, 32'd0);
        run_op("remu_z", 4'd14, 32'd5, 32'd0);

        // back-to-back single-cycle accepts
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom; op = 4'($urandom_range(0, 10));
            valid_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b;
            exp_q.push_back(model_result(op, a, b));
            @(posedge clk); #1;
            chk("b2b_valid", 64'(valid_o), 64'd1);
            chk("b2b_res", 64'(result_o), 64'(exp_q.pop_front()));
            @(negedge clk);
        end
        valid_i = 1'b0;

        // reset in the middle of a multiply
        @(negedge clk);
        valid_i = 1'b1; op_i = 4'd11; operand_a_i = 32'd3; operand_b_i = 32'd5;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk("abort_ready", 64'(ready_o), 64'd1);
        chk("abort_valid", 64'(valid_o), 64'd0);
        chk("abort_result", 64'(result_o), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_o) seen = 1;
        end
        chk("abort_noval", 64'(seen), 64'd0);
        run_op("after_abort", 4'd0, 32'd20, 32'd22);

        // reset wins over a simultaneous request
        @(negedge clk);
        rst_i = 1'b1; valid_i = 1'b1; op_i = 4'd0; operand_a_i = 32'd5; operand_b_i = 32'd6;
        @(posedge clk); #1;
        rst_i = 1'b0; valid_i = 1'b0;
        chk("rst_ovr_valid", 64'(valid_o), 64'd0);
        chk("rst_ovr_result", 64'(result_o), 64'd0);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 300));
            run_op("rand", op, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
